// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive control: frame-safe config apply, show-ahead RX FIFO, optional idle timeout (RX_TIMEOUT_EN)
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH   = 8,
    parameter int          ADDR_W       = 3,
    parameter logic [15:0] DEFAULT_DIV  = 16'd32,
    parameter int          TIMEOUT_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic              cfg_enable,
    input  logic [15:0]       cfg_baud_div,
    output logic [15:0]       baud_div,
    output logic              rx_en,
    input  logic              baud_tick_16x,
    input  logic              rx_busy,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              ctrl_busy,
    output logic              timeout_irq
);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN, S_APPLY} state_t;

    state_t      state;
    logic        pend_valid;
    logic        pend_en;
    logic [15:0] pend_div;

    // Control FSM; pending config and every control output are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OFF;
            rx_en      <= 1'b0;
            baud_div   <= DEFAULT_DIV;
            pend_valid <= 1'b0;
            pend_en    <= 1'b0;
            pend_div   <= 16'd0;
        end else begin
            case (state)
                S_OFF: begin
                    if (pend_valid) begin
                        state <= S_APPLY;
                        rx_en <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (pend_valid) begin
                        if (rx_busy) begin
                            state <= S_DRAIN;
                            rx_en <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                            rx_en <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!rx_busy) begin
                        state <= S_APPLY;
                        rx_en <= 1'b0;
                    end
                end
                default: begin
                    // APPLY: the only place the divider moves; rx_en was low for this cycle
                    baud_div <= pend_div;
                    state    <= pend_en ? S_RUN : S_OFF;
                    rx_en    <= pend_en;
                end
            endcase

            // A write in the APPLY cycle survives as the next pending config
            if (cfg_wr) begin
                pend_valid <= 1'b1;
                pend_en    <= cfg_enable;
                pend_div   <= cfg_baud_div;
            end else if (state == S_APPLY) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign ctrl_busy = pend_valid;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [7:0]      head_q;
    logic [7:0]      head_nxt;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop   = rd_en && !empty;
    assign push  = rx_done && (!full || pop);
    assign drop  = rx_done && full && !pop;

    assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};

    // Next show-ahead head: bypass the incoming byte when it becomes the head
    always_comb begin
        head_nxt = head_q;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (push && (rd_ptr_nxt[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0]))
                head_nxt = rx_data;
            else
                head_nxt = mem[rd_ptr_nxt[ADDR_W-1:0]];
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
    end

    // FIFO pointers, registered head and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            head_q  <= 8'd0;
            overrun <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            head_q <= head_nxt;
            if (drop)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    assign rd_data    = head_q;
    assign rd_empty   = empty;
    assign fifo_count = wr_ptr - rd_ptr;

    logic unused_params;
    assign unused_params = ^{FIFO_DEPTH[0]};

`ifdef RX_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_BITS * 16);

    logic [15:0] to_cnt;
    logic        to_irq;
    logic        to_inc;

    assign to_inc = baud_tick_16x && !empty && (to_cnt != TO_LIMIT);

    // Idle timeout: count oversample ticks while bytes sit unread and the line is quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= 16'd0;
            to_irq <= 1'b0;
        end else begin
            if (rx_busy || rx_done || pop || (state != S_RUN))
                to_cnt <= 16'd0;
            else if (to_inc)
                to_cnt <= to_cnt + 16'd1;

            if (pop || empty)
                to_irq <= 1'b0;
            else if ((state == S_RUN) && !rx_busy && !rx_done && to_inc &&
                     (to_cnt == TO_LIMIT - 16'd1))
                to_irq <= 1'b1;
        end
    end

    assign timeout_irq = to_irq;
`else
    logic unused_tick;
    assign unused_tick = baud_tick_16x ^ TIMEOUT_BITS[0];
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a queue-based FIFO model
module tb_uart_rx_ctrl;

`ifdef RX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic        cfg_enable;
    logic [15:0] cfg_baud_div;
    logic [15:0] baud_div;
    logic        rx_en;
    logic        baud_tick_16x;
    logic        rx_busy;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        ovr_clr;
    logic        ctrl_busy;
    logic        timeout_irq;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q [$];
    logic        m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr       (cfg_wr),
        .cfg_enable   (cfg_enable),
        .cfg_baud_div (cfg_baud_div),
        .baud_div     (baud_div),
        .rx_en        (rx_en),
        .baud_tick_16x(baud_tick_16x),
        .rx_busy      (rx_busy),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_empty     (rd_empty),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr),
        .ctrl_busy    (ctrl_busy),
        .timeout_irq  (timeout_irq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clocked cycle of FIFO traffic, with the reference queue updated alongside
    task automatic step(input logic done, input logic [7:0] d, input logic rd, input logic clr);
        bit p;
        bit dropped;
        rx_done = done;
        rx_data = d;
        rd_en   = rd;
        ovr_clr = clr;
        p       = rd && (q.size() != 0);
        dropped = done && (q.size() == 8) && !p;
        if (p) void'(q.pop_front());
        if (done && !dropped) q.push_back(d);
        if (dropped) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        cyc();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(rd_empty), 32'(q.size() == 0));
        chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        if (q.size() != 0) chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
    endtask

    // Behavioural receiver: a frame only completes when the receiver is enabled
    task automatic recv(input logic [7:0] b, input int n);
        if (rx_en) begin
            rx_busy = 1'b1;
            repeat (n) cyc();
            rx_busy = 1'b0;
            step(1'b1, b, 1'b0, 1'b0);
        end else begin
            repeat (n + 1) cyc();
        end
    endtask

    task automatic cfg(input logic en, input logic [15:0] div);
        cfg_wr       = 1'b1;
        cfg_enable   = en;
        cfg_baud_div = div;
        cyc();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_enable = 1'b0; cfg_baud_div = 16'd0;
        baud_tick_16x = 1'b0; rx_busy = 1'b0; rx_done = 1'b0; rx_data = 8'd0;
        rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (3) cyc();

        chk("rst_div", 32'(baud_div), 32'd32);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_empty", 32'(rd_empty), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(ctrl_busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(timeout_irq), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_rx_en", 32'(rx_en), 32'd0);
        chk("post_rst_busy", 32'(ctrl_busy), 32'd0);

        // Enable from OFF: busy next cycle, APPLY 2 cycles in, rx_en high 3 cycles in
        cfg(1'b1, 16'd32);
        chk("en_busy1", 32'(ctrl_busy), 32'd1);
        chk("en_rx_en1", 32'(rx_en), 32'd0);
        cyc();
        chk("en_apply_rx_en", 32'(rx_en), 32'd0);
        cyc();
        chk("en_rx_en3", 32'(rx_en), 32'd1);
        chk("en_busy3", 32'(ctrl_busy), 32'd0);
        chk("en_div", 32'(baud_div), 32'd32);

        recv(8'hAA, 5);
        recv(8'hAB, 5);
        check_fifo("two_bytes");
        chk("two_head", 32'(rd_data), 32'hAA);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_fifo("pop1");
        chk("pop1_head", 32'(rd_data), 32'hAB);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("pop2_empty", 32'(rd_empty), 32'd1);

        // Reconfigure mid-frame, last write wins, apply waits for the frame to end
        rx_busy = 1'b1;
        repeat (3) cyc();
        cfg(1'b1, 16'd8);
        cfg(1'b1, 16'd16);
        chk("drain_busy", 32'(ctrl_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_div", 32'(baud_div), 32'd32);
            chk("drain_rx_en", 32'(rx_en), 32'd1);
        end
        rx_busy = 1'b0;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("apply_rx_en", 32'(rx_en), 32'd0);
        chk("apply_div_old", 32'(baud_div), 32'd32);
        chk("apply_busy", 32'(ctrl_busy), 32'd1);
        check_fifo("drain_byte");
        cyc();
        chk("applied_div", 32'(baud_div), 32'd16);
        chk("applied_rx_en", 32'(rx_en), 32'd1);
        chk("applied_busy", 32'(ctrl_busy), 32'd0);
        recv(8'h3C, 5);
        check_fifo("div16_byte");
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("div16_head", 32'(rd_data), 32'h3C);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_fifo("t3_drained");

        // Overflow: nine bytes into eight entries
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ovr", 32'(overrun), 32'd1);
        chk("full_head", 32'(rd_data), 32'h01);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_pp_count", 32'(fifo_count), 32'd8);
        chk("full_pp_ovr", 32'(overrun), 32'd0);
        check_fifo("full_pp");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            check_fifo("drain_full");
        end

        // Randomised push/pop/clear traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 (i < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
            check_fifo("rand");
            chk("rand_irq", 32'(timeout_irq), 32'd0);
        end
        for (int i = 0; i < 9; i++) begin
            if (q.size() != 0) step(1'b0, 8'd0, 1'b1, 1'b0);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check_fifo("rand_drained");

        // Disable while idle: APPLY then OFF, no frames complete
        cfg(1'b0, 16'd32);
        cyc();
        chk("off_apply_rx_en", 32'(rx_en), 32'd0);
        cyc();
        chk("off_rx_en", 32'(rx_en), 32'd0);
        chk("off_busy", 32'(ctrl_busy), 32'd0);
        chk("off_div", 32'(baud_div), 32'd32);
        recv(8'h77, 5);
        check_fifo("off_no_push");
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("off_stays", 32'(rx_en), 32'd0);
        end

        // Idle timeout after 64 oversample ticks with a byte waiting
        cfg(1'b1, 16'd32);
        repeat (2) cyc();
        chk("t6_rx_en", 32'(rx_en), 32'd1);
        recv(8'h5A, 3);
        check_fifo("t6_byte");
        baud_tick_16x = 1'b1;
        repeat (63) cyc();
        baud_tick_16x = 1'b0;
        cyc();
        chk("to_before", 32'(timeout_irq), 32'd0);
        baud_tick_16x = 1'b1;
        cyc();
        baud_tick_16x = 1'b0;
        chk("to_after", 32'(timeout_irq), 32'(TO_EN));
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("to_pop_clear", 32'(timeout_irq), 32'd0);
        check_fifo("t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
